// File: rtl/fft_buf_pkg.sv
`default_nettype none
// ============================================================================
// fft_buf_pkg : shared constants and bit-reverse helper for fft_frame_buf_ctrl  (rev 1.0)
// ============================================================================
package fft_buf_pkg;

  localparam int LOG2_N_DEF = 7;
  localparam int MAX_IDX_W  = 16;
  localparam int NUM_BANKS  = 2;
  localparam logic BANK0    = 1'b0;

  // Reverses the low w bits of v by shifting them out LSB-first into r.
  function automatic logic [MAX_IDX_W-1:0] bitrev(input logic [MAX_IDX_W-1:0] v,
                                                  input int w);
    logic [MAX_IDX_W-1:0] s;
    logic [MAX_IDX_W-1:0] r;
    s = v;
    r = '0;
    for (int i = 0; i < MAX_IDX_W; i++) begin
      if (i < w) begin
        r = {r[MAX_IDX_W-2:0], s[0]};
        s = s >> 1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_buf_skid.sv
`default_nettype none
// ============================================================================
// fft_buf_skid : 2-entry register FIFO holding RAM read words and their last tag  (rev 1.0)
// ============================================================================
module fft_buf_skid #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       cnt_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = data_i;
        else               tail_d = data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // pop implies non-empty, so occupancy is 1 or 2 here
        if (cnt_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = (cnt_q != 2'd0);
  assign cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fft_frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
// fft_frame_buf_ctrl : ping-pong frame controller for one dual-port fft_ram  (rev 1.0)
// ============================================================================
module fft_frame_buf_ctrl
  import fft_buf_pkg::*;
#(
  parameter int LOG2_N = LOG2_N_DEF,
  parameter int DATA_W = 64,
  parameter bit BITREV = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              ram_wr_en,
  output logic [LOG2_N:0]   ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [LOG2_N:0]   ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [15:0]       frames_out
);

  localparam logic [LOG2_N-1:0] IDX_LAST = '1;

  logic [NUM_BANKS-1:0] full_q, full_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [LOG2_N-1:0]    wr_idx_q, wr_idx_d;
  logic [LOG2_N-1:0]    rd_idx_q, rd_idx_d;
  logic [15:0]          frames_q, frames_d;
  logic                 live_q;
  logic                 inflight_q;
  logic                 inflight_last_q;

  logic                 wr_fire;
  logic                 rd_issue;
  logic                 pop;
  logic [1:0]           skid_cnt;
  logic [2:0]           occ;
  logic [LOG2_N-1:0]    rd_addr_idx;
  logic [DATA_W:0]      skid_head;

  // live_q keeps s_ready low while reset is asserted
  assign s_ready  = live_q & ~full_q[wr_bank_q];
  assign wr_fire  = s_valid & s_ready;
  assign pop      = m_valid & m_ready;
  // Occupancy after this cycle's pop; lets the reader sustain 1 word/cycle.
  assign occ      = {1'b0, skid_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue = full_q[rd_bank_q] & (occ < 3'd2);

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    frames_d  = frames_q;
    if (wr_fire) begin
      if (wr_idx_q == IDX_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + LOG2_N'(1);
      end
    end
    // Write needs its bank empty, read needs its bank full: never the same bit.
    if (rd_issue) begin
      if (rd_idx_q == IDX_LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        rd_idx_d = rd_idx_q + LOG2_N'(1);
      end
    end
    if (pop && m_last) frames_d = frames_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q          <= '0;
      wr_bank_q       <= BANK0;
      rd_bank_q       <= BANK0;
      wr_idx_q        <= '0;
      rd_idx_q        <= '0;
      frames_q        <= 16'd0;
      live_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      full_q          <= full_d;
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      wr_idx_q        <= wr_idx_d;
      rd_idx_q        <= rd_idx_d;
      frames_q        <= frames_d;
      live_q          <= 1'b1;
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue & (rd_idx_q == IDX_LAST);
    end
  end

  generate
    if (BITREV) begin : g_rev
      assign rd_addr_idx = LOG2_N'(bitrev(MAX_IDX_W'(rd_idx_q), LOG2_N));
    end else begin : g_nat
      assign rd_addr_idx = rd_idx_q;
    end
  endgenerate

  fft_buf_skid #(
    .WIDTH (DATA_W + 1)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .data_i  ({inflight_last_q, ram_rd_data}),
    .pop_i   (pop),
    .data_o  (skid_head),
    .valid_o (m_valid),
    .cnt_o   (skid_cnt)
  );

  assign m_data      = skid_head[DATA_W-1:0];
  assign m_last      = skid_head[DATA_W];
  assign ram_wr_en   = wr_fire;
  assign ram_wr_addr = {wr_bank_q, wr_idx_q};
  assign ram_wr_data = s_data;
  assign ram_rd_addr = {rd_bank_q, rd_addr_idx};
  assign frames_out  = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_buf_ctrl.sv
`default_nettype none
// tb_fft_frame_buf_ctrl : two controllers (bit-reversed and natural) on shared stimulus,
// each with its own RAM, compared against a frame-level reference model.
module tb_fft_frame_buf_ctrl;

  localparam int L  = 3;
  localparam int N  = 1 << L;
  localparam int DW = 64;
  localparam int AW = L + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;

  logic          s_ready_r, m_valid_r, m_last_r, wr_en_r;
  logic [DW-1:0] m_data_r, wr_data_r, rd_data_r;
  logic [AW-1:0] wr_addr_r, rd_addr_r;
  logic [15:0]   frames_r;
  logic          s_ready_n, m_valid_n, m_last_n, wr_en_n;
  logic [DW-1:0] m_data_n, wr_data_n, rd_data_n;
  logic [AW-1:0] wr_addr_n, rd_addr_n;
  logic [15:0]   frames_n;

  fft_frame_buf_ctrl #(.LOG2_N(L), .DATA_W(DW), .BITREV(1'b1)) u_dut_rev (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_r), .s_data(s_data),
    .m_valid(m_valid_r), .m_ready(m_ready), .m_data(m_data_r), .m_last(m_last_r),
    .ram_wr_en(wr_en_r), .ram_wr_addr(wr_addr_r), .ram_wr_data(wr_data_r),
    .ram_rd_addr(rd_addr_r), .ram_rd_data(rd_data_r), .frames_out(frames_r));

  fft_frame_buf_ctrl #(.LOG2_N(L), .DATA_W(DW), .BITREV(1'b0)) u_dut_nat (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_n), .s_data(s_data),
    .m_valid(m_valid_n), .m_ready(m_ready), .m_data(m_data_n), .m_last(m_last_n),
    .ram_wr_en(wr_en_n), .ram_wr_addr(wr_addr_n), .ram_wr_data(wr_data_n),
    .ram_rd_addr(rd_addr_n), .ram_rd_data(rd_data_n), .frames_out(frames_n));

  logic [DW-1:0] mem_r [2*N];
  logic [DW-1:0] mem_n [2*N];
  always @(posedge clk) begin
    if (wr_en_r) mem_r[wr_addr_r] <= wr_data_r;
    rd_data_r <= mem_r[rd_addr_r];
    if (wr_en_n) mem_n[wr_addr_n] <= wr_data_n;
    rd_data_n <= mem_n[rd_addr_n];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rev(input int i);
    int r;
    r = 0;
    for (int b = 0; b < L; b++)
      if (((i >> b) & 1) != 0) r += 1 << (L - 1 - b);
    return r;
  endfunction

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  logic [DW-1:0] cur_frame[$];
  exp_t          exp_r[$];
  exp_t          exp_n[$];
  int            frames_exp = 0;
  int            cyc = 0;
  int            pops = 0;
  int            pop_mark = 0;
  int            first_pop_cyc = 0;
  int            last_pop_cyc = 0;

  // Reference model: a completed input frame becomes N expected output words.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (s_valid && s_ready_r) begin
        cur_frame.push_back(s_data);
        if (cur_frame.size() == N) begin
          for (int i = 0; i < N; i++) begin
            exp_r.push_back('{d: cur_frame[rev(i)], last: (i == N - 1)});
            exp_n.push_back('{d: cur_frame[i], last: (i == N - 1)});
          end
          cur_frame.delete();
        end
      end
      if (m_valid_r && m_ready) begin
        if (exp_r.size() == 0) begin
          check("out_rev_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_r.pop_front();
          check("data_rev", m_data_r, e.d);
          check("last_rev", {63'd0, m_last_r}, {63'd0, e.last});
          if (e.last) frames_exp++;
        end
        if (pops == pop_mark) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pops++;
      end
      if (m_valid_n && m_ready) begin
        if (exp_n.size() == 0) begin
          check("out_nat_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_n.pop_front();
          check("data_nat", m_data_n, e.d);
          check("last_nat", {63'd0, m_last_n}, {63'd0, e.last});
        end
      end
    end
  end

  logic [DW-1:0] next_val = '0;
  bit            rand_data = 1'b0;
  int            sent = 0;
  int            stalls = 0;

  task automatic cycle(input int pv, input int pr);
    @(posedge clk);
    #1;
    s_valid = ($urandom_range(99) < pv);
    s_data  = next_val;
    m_ready = ($urandom_range(99) < pr);
    @(negedge clk);
    #1;
    if (s_valid && s_ready_r) begin
      sent++;
      next_val = rand_data ? {$urandom, $urandom} : next_val + 64'd1;
    end else if (s_valid) begin
      stalls++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    cur_frame.delete();
    exp_r.delete();
    exp_n.delete();
    frames_exp = 0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", {63'd0, s_ready_r}, 64'd0);
    check("rst_m_valid", {63'd0, m_valid_r}, 64'd0);
    check("rst_m_last", {63'd0, m_last_r}, 64'd0);
    check("rst_m_data", m_data_r, 64'd0);
    check("rst_wr_en", {63'd0, wr_en_r}, 64'd0);
    check("rst_wr_addr", {60'd0, wr_addr_r}, 64'd0);
    check("rst_rd_addr", {60'd0, rd_addr_r}, 64'd0);
    check("rst_frames", {48'd0, frames_r}, 64'd0);
    check("rst_nat_rd_addr", {60'd0, rd_addr_n}, 64'd0);
    check("rst_nat_s_ready", {63'd0, s_ready_n}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("release_s_ready", {63'd0, s_ready_r}, 64'd1);
  endtask

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while ((exp_r.size() != 0 || m_valid_r) && k < max_cyc) begin
      cycle(0, 100);
      k++;
    end
    repeat (4) cycle(0, 100);
    check("drain_rev_empty", 64'(exp_r.size()), 64'd0);
    check("drain_nat_empty", 64'(exp_n.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int k;
    int st0;
    do_reset();

    // One frame 0..7, then first-word latency after the last accept.
    next_val = '0;
    s0 = sent;
    k = 0;
    while (sent - s0 < N && k < 50) begin cycle(100, 100); k++; end
    check("t1_sent", 64'(sent - s0), 64'(N));
    cycle(0, 100);
    check("lat_edge_k", {63'd0, m_valid_r}, 64'd0);
    cycle(0, 100);
    check("lat_edge_k1", {63'd0, m_valid_r}, 64'd0);
    cycle(0, 100);
    check("lat_edge_k2", {63'd0, m_valid_r}, 64'd1);
    drain(40);
    check("t1_frames_rev", {48'd0, frames_r}, 64'd1);
    check("t1_frames_nat", {48'd0, frames_n}, 64'd1);
    check("t1_rd_bank_rev", {60'd0, rd_addr_r}, 64'(N));
    check("t1_rd_bank_nat", {60'd0, rd_addr_n}, 64'(N));
    check("t1_wr_bank", {60'd0, wr_addr_r}, 64'(N));

    // Four back-to-back frames with no stalls and no output gaps.
    pop_mark = pops;
    s0 = sent;
    st0 = stalls;
    for (int c = 0; c < 4 * N; c++) cycle(100, 100);
    check("t2_sent", 64'(sent - s0), 64'(4 * N));
    check("t2_stalls", 64'(stalls - st0), 64'd0);
    drain(60);
    check("t2_pops", 64'(pops - pop_mark), 64'(4 * N));
    check("t2_out_span", 64'(last_pop_cyc - first_pop_cyc), 64'(4 * N - 1));
    check("t2_frames", {48'd0, frames_r}, 64'd5);
    check("t2_rd_bank_nat", {60'd0, rd_addr_n}, 64'(N));

    // Downstream stalled for 40 cycles: both banks fill, writer blocks.
    s0 = sent;
    repeat (40) cycle(100, 0);
    check("t3_sent", 64'(sent - s0), 64'(2 * N));
    check("t3_s_ready_low", {63'd0, s_ready_r}, 64'd0);
    check("t3_m_valid_held", {63'd0, m_valid_r}, 64'd1);
    drain(100);
    check("t3_frames", {48'd0, frames_r}, 64'd7);

    // 100 frames of random data under random valid/ready.
    rand_data = 1'b1;
    next_val  = {$urandom, $urandom};
    s0 = sent;
    k = 0;
    while (sent - s0 < 100 * N && k < 20000) begin cycle(70, 50); k++; end
    check("t4_sent", 64'(sent - s0), 64'(100 * N));
    drain(2000);
    check("t4_frames_rev", {48'd0, frames_r}, 64'd107);
    check("t4_frames_nat", {48'd0, frames_n}, 64'd107);
    check("t4_frames_model", {48'd0, frames_r}, 64'(frames_exp));

    // Reset at word 5 of the second frame, then a fresh frame from bank 0.
    rand_data = 1'b0;
    next_val  = 64'd100;
    s0 = sent;
    k = 0;
    while (sent - s0 < N + 5 && k < 100) begin cycle(100, 100); k++; end
    check("t6_pre_sent", 64'(sent - s0), 64'(N + 5));
    do_reset();
    next_val = 64'd200;
    s0 = sent;
    cycle(100, 100);
    check("t6_wr_en", {63'd0, wr_en_r}, 64'd1);
    check("t6_wr_addr", {60'd0, wr_addr_r}, 64'd0);
    k = 0;
    while (sent - s0 < N && k < 50) begin cycle(100, 100); k++; end
    check("t6_sent", 64'(sent - s0), 64'(N));
    drain(40);
    check("t6_frames", {48'd0, frames_r}, 64'd1);
    check("t6_rd_bank", {60'd0, rd_addr_r}, 64'(N));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
